mod7_seek_arb: RTL and testbench

MOD7_SEEK_ARB -- requirements
Module: mod7_seek_arb

---
 rtl/mod7_seek_arb_pkg.sv | 31 +++
 rtl/mod7_seek_arb_if.sv | 29 ++
 rtl/mod7_seek_arb_mod7.sv | 27 ++
 rtl/mod7_seek_arb.sv | 126 ++++++++++++
 tb/tb_mod7_seek_arb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod7_seek_arb_pkg.sv
// Shared types and helpers for the two-requester mod-7 seek arbiter.
// Holds the FSM state encoding, ring constants and the modular difference helper.
package mod7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] MOD         = 3'd7;
  localparam logic [2:0] MAX_STEP    = 3'd3;
  localparam logic [2:0] INVALID_POS = 3'd7;

  // (a - b) mod 7; with 3-bit operands a + 7 - b stays within 0..14.
  function automatic logic [2:0] mod_sub(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] t;
    t = {1'b0, a} + 4'd7 - {1'b0, b};
    if (t >= 4'd14)
      t = t - 4'd14;
    else if (t >= 4'd7)
      t = t - 4'd7;
    return t[2:0];
  endfunction

  function automatic logic [1:0] onehot(input logic id);
    return {id, ~id};
  endfunction

endpackage

// File: rtl/mod7_seek_arb_if.sv
// Request/grant bundle between the seek requesters and the arbiter.
// req is a level held until done/err; dropping it early aborts the seek. gnt is
// registered and stays high for the whole transaction; done/err pulse one cycle.
interface mod7_seek_arb_if;
  import mod7_pkg::*;

  logic [1:0] req;
  logic [2:0] target0;
  logic [2:0] target1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [1:0] err;
  logic       busy;
  logic [2:0] value;
  logic       cnt_dir;
  logic       cnt_now;
  state_t     dbg_state;

  modport slave (
    input  req, target0, target1,
    output gnt, done, err, busy, value, cnt_dir, cnt_now, dbg_state
  );

  modport master (
    output req, target0, target1,
    input  gnt, done, err, busy, value, cnt_dir, cnt_now, dbg_state
  );

endinterface

// File: rtl/mod7_seek_arb_mod7.sv
// Mod-7 up/down position counter: steps once per enabled clock, wrapping 6<->0.
module mod7
  import mod7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic       now,
  output logic [2:0] value
);

  logic [2:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 3'd0;
    end else if (now) begin
      if (dir)
        r_value <= (r_value == MOD - 3'd1) ? 3'd0 : r_value + 3'd1;
      else
        r_value <= (r_value == 3'd0) ? MOD - 3'd1 : r_value - 3'd1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/mod7_seek_arb.sv
// Round-robin arbiter that grants one of two requesters a shortest-path seek
// of the shared mod-7 counter to that requester's target position.
module mod7_seek_arb
  import mod7_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mod7_seek_arb_if.slave   bus
);

  state_t     r_state, w_nxt_state;
  logic [1:0] r_gnt, w_nxt_gnt;
  logic       r_owner, w_nxt_owner;
  logic [2:0] r_target, w_nxt_target;
  logic       r_dir, w_nxt_dir;
  logic [2:0] r_rem, w_nxt_rem;
  logic       r_ptr, w_nxt_ptr;

  logic       w_pick;
  logic [2:0] w_sel_target;
  logic [2:0] w_d_up;
  logic [2:0] w_value;
  logic       w_now;

  // On contention r_ptr names the requester that was not served last.
  assign w_pick       = (bus.req == 2'b11) ? r_ptr : bus.req[1];
  assign w_sel_target = w_pick ? bus.target1 : bus.target0;
  assign w_d_up       = mod_sub(w_sel_target, w_value);
  assign w_now        = (r_state == SEEK) && bus.req[r_owner];

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_gnt    = r_gnt;
    w_nxt_owner  = r_owner;
    w_nxt_target = r_target;
    w_nxt_dir    = r_dir;
    w_nxt_rem    = r_rem;
    w_nxt_ptr    = r_ptr;
    case (r_state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          w_nxt_owner  = w_pick;
          w_nxt_target = w_sel_target;
          w_nxt_gnt    = onehot(w_pick);
          if (w_sel_target == INVALID_POS) begin
            w_nxt_state = ERR;
          end else if (w_d_up == 3'd0) begin
            w_nxt_state = DONE;
          end else if (w_d_up <= MAX_STEP) begin
            w_nxt_state = SEEK;
            w_nxt_dir   = 1'b1;
            w_nxt_rem   = w_d_up;
          end else begin
            w_nxt_state = SEEK;
            w_nxt_dir   = 1'b0;
            w_nxt_rem   = MOD - w_d_up;
          end
        end
      end
      SEEK: begin
        if (!bus.req[r_owner]) begin
          w_nxt_state = IDLE;
          w_nxt_gnt   = 2'b00;
          w_nxt_ptr   = ~r_owner;
        end else begin
          w_nxt_rem = r_rem - 3'd1;
          if (r_rem == 3'd1)
            w_nxt_state = DONE;
        end
      end
      DONE, ERR: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = 2'b00;
        w_nxt_ptr   = ~r_owner;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= 2'b00;
      r_owner  <= 1'b0;
      r_target <= 3'd0;
      r_dir    <= 1'b1;
      r_rem    <= 3'd0;
      r_ptr    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_gnt    <= w_nxt_gnt;
      r_owner  <= w_nxt_owner;
      r_target <= w_nxt_target;
      r_dir    <= w_nxt_dir;
      r_rem    <= w_nxt_rem;
      r_ptr    <= w_nxt_ptr;
    end
  end

  // The step count is derived once at grant; arrival must land on the latched target.
  always_comb begin
    if (r_state == DONE)
      assert (w_value == r_target);
  end

  mod7 u_cnt (
    .clk   (clk),
    .rst   (rst),
    .dir   (r_dir),
    .now   (w_now),
    .value (w_value)
  );

  assign bus.gnt       = r_gnt;
  assign bus.done      = (r_state == DONE) ? onehot(r_owner) : 2'b00;
  assign bus.err       = (r_state == ERR)  ? onehot(r_owner) : 2'b00;
  assign bus.busy      = (r_state != IDLE);
  assign bus.cnt_now   = w_now;
  assign bus.cnt_dir   = r_dir;
  assign bus.value     = w_value;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mod7_seek_arb.sv
// Bench for mod7_seek_arb: directed scenarios with literal expectations, then
// randomized requests checked every cycle against a transaction-level model.
module tb_mod7_seek_arb;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mod7_seek_arb_if bus ();

  mod7_seek_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // A transaction is: owner, latched target, and the list of unit moves still to make.
  bit m_valid;
  int m_val, m_ptr, m_own, m_kind, m_tgt, m_dir;
  int m_steps[$];
  int m_who, m_t, m_d;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_val   = 0;
      m_ptr   = 0;
      m_own   = -1;
      m_dir   = 1;
      m_kind  = 0;
      m_steps.delete();
    end else if (m_valid) begin
      if (m_own < 0) begin
        if (bus.req != 2'b00) begin
          m_who = (bus.req == 2'b11) ? m_ptr : (bus.req[1] ? 1 : 0);
          m_t   = (m_who == 1) ? int'(bus.target1) : int'(bus.target0);
          m_own = m_who;
          m_tgt = m_t;
          m_steps.delete();
          if (m_t == 7) begin
            m_kind = 2;
          end else begin
            m_kind = 1;
            m_d = (m_t - m_val + 7) % 7;
            if (m_d >= 1 && m_d <= 3)
              repeat (m_d) m_steps.push_back(1);
            else if (m_d >= 4)
              repeat (7 - m_d) m_steps.push_back(-1);
            if (m_steps.size() > 0)
              m_dir = (m_steps[0] > 0) ? 1 : 0;
          end
        end
      end else if (m_steps.size() > 0) begin
        if (!bus.req[m_own]) begin
          m_ptr = 1 - m_own;
          m_own = -1;
          m_steps.delete();
        end else begin
          m_val = (m_val + m_steps.pop_front() + 7) % 7;
        end
      end else begin
        m_ptr = 1 - m_own;
        m_own = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int e_gnt, e_done, e_err, e_now;
  bit seeking, pulsing;

  always @(negedge clk) begin
    if (m_valid) begin
      seeking = (m_own >= 0) && (m_steps.size() > 0);
      pulsing = (m_own >= 0) && (m_steps.size() == 0);
      e_gnt   = (m_own < 0) ? 0 : (1 << m_own);
      e_now   = seeking ? int'(bus.req[m_own]) : 0;
      e_done  = (pulsing && m_kind == 1) ? e_gnt : 0;
      e_err   = (pulsing && m_kind == 2) ? e_gnt : 0;
      chk("gnt",     int'(bus.gnt),     e_gnt);
      chk("busy",    int'(bus.busy),    (m_own >= 0) ? 1 : 0);
      chk("value",   int'(bus.value),   m_val);
      chk("cnt_now", int'(bus.cnt_now), e_now);
      chk("cnt_dir", int'(bus.cnt_dir), m_dir);
      chk("done",    int'(bus.done),    e_done);
      chk("err",     int'(bus.err),     e_err);
      if (e_done != 0)
        chk("done_at_target", int'(bus.value), m_tgt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input int id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      smp();
      if (bus.done[id] || bus.err[id])
        got = 1'b1;
    end
    chk("pulse_within_bound", int'(got), 1);
  endtask

  task automatic run_seek(input int id, input logic [2:0] tgt);
    cyc();
    bus.req = 2'b00;
    bus.req[id] = 1'b1;
    if (id == 1) bus.target1 = tgt;
    else         bus.target0 = tgt;
    wait_pulse(id);
    cyc();
    bus.req = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.req     = 2'b00;
    bus.target0 = 3'd0;
    bus.target1 = 3'd0;
    repeat (3) cyc();
    smp();
    chk("rst_value",   int'(bus.value),   0);
    chk("rst_gnt",     int'(bus.gnt),     0);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_cnt_dir", int'(bus.cnt_dir), 1);
    chk("rst_cnt_now", int'(bus.cnt_now), 0);

    // up seek 0 -> 3
    cyc(); rst = 1'b0; bus.req = 2'b01; bus.target0 = 3'd3;
    cyc(); smp(); chk("s1_gnt", int'(bus.gnt), 1); chk("s1_v0", int'(bus.value), 0);
    cyc(); smp(); chk("s1_v1", int'(bus.value), 1);
    cyc(); smp(); chk("s1_v2", int'(bus.value), 2);
    cyc(); smp(); chk("s1_v3", int'(bus.value), 3); chk("s1_done", int'(bus.done), 1);
    cyc(); bus.req = 2'b00; smp(); chk("s1_idle_gnt", int'(bus.gnt), 0);

    // down seek 1 -> 5 (d_up = 4)
    run_seek(0, 3'd1);
    cyc(); bus.req = 2'b10; bus.target1 = 3'd5;
    cyc(); smp(); chk("s2_gnt", int'(bus.gnt), 2); chk("s2_dir", int'(bus.cnt_dir), 0);
    cyc(); smp(); chk("s2_v0", int'(bus.value), 0);
    cyc(); smp(); chk("s2_v6", int'(bus.value), 6);
    cyc(); smp(); chk("s2_v5", int'(bus.value), 5); chk("s2_done", int'(bus.done), 2);
    cyc(); bus.req = 2'b00;

    // contention at value 2: zero-step req0, then req1 down to 6 ignoring target change
    run_seek(1, 3'd2);
    cyc(); bus.req = 2'b11; bus.target0 = 3'd2; bus.target1 = 3'd6;
    cyc(); smp(); chk("s3_gnt0", int'(bus.gnt), 1); chk("s3_done0", int'(bus.done), 1);
    chk("s3_v2", int'(bus.value), 2);
    cyc(); smp(); chk("s3_idle", int'(bus.busy), 0);
    cyc(); bus.target1 = 3'd0; smp(); chk("s3_gnt1", int'(bus.gnt), 2);
    cyc(); smp(); chk("s3_v1", int'(bus.value), 1);
    cyc(); smp(); chk("s3_v0", int'(bus.value), 0);
    cyc(); smp(); chk("s3_v6", int'(bus.value), 6); chk("s3_done1", int'(bus.done), 2);
    cyc(); bus.req = 2'b00;

    // invalid target
    cyc(); bus.req = 2'b01; bus.target0 = 3'd7;
    cyc(); smp(); chk("s4_err", int'(bus.err), 1); chk("s4_gnt", int'(bus.gnt), 1);
    chk("s4_v6", int'(bus.value), 6); chk("s4_done", int'(bus.done), 0);
    cyc(); bus.req = 2'b00; smp(); chk("s4_err_clr", int'(bus.err), 0);

    // abort after one step, pending req1 then granted
    run_seek(0, 3'd0);
    cyc(); bus.req = 2'b01; bus.target0 = 3'd3;
    cyc(); bus.req = 2'b11; bus.target1 = 3'd5; smp(); chk("s5_gnt0", int'(bus.gnt), 1);
    cyc(); bus.req = 2'b10; smp(); chk("s5_v1", int'(bus.value), 1);
    chk("s5_now_off", int'(bus.cnt_now), 0);
    cyc(); smp(); chk("s5_gnt_clr", int'(bus.gnt), 0); chk("s5_hold", int'(bus.value), 1);
    chk("s5_no_done", int'(bus.done), 0);
    cyc(); smp(); chk("s5_gnt1", int'(bus.gnt), 2);
    wait_pulse(1);
    chk("s5_v5", int'(bus.value), 5);
    cyc(); bus.req = 2'b00;

    // reset during seek 5 -> 1
    cyc(); bus.req = 2'b01; bus.target0 = 3'd1;
    cyc(); smp(); chk("s6_gnt", int'(bus.gnt), 1);
    cyc(); smp(); chk("s6_v6", int'(bus.value), 6);
    cyc(); rst = 1'b1; smp(); chk("s6_v0_pre", int'(bus.value), 0);
    cyc(); rst = 1'b0; bus.req = 2'b00; smp();
    chk("s6_value", int'(bus.value), 0); chk("s6_gnt_rst", int'(bus.gnt), 0);
    chk("s6_busy", int'(bus.busy), 0); chk("s6_done", int'(bus.done), 0);

    // randomized traffic; the model checks every cycle
    for (int i = 0; i < 600; i++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) bus.req[0] = ~bus.req[0];
      if ($urandom_range(0, 5) == 0) bus.req[1] = ~bus.req[1];
      bus.target0 = 3'($urandom_range(0, 7));
      bus.target1 = 3'($urandom_range(0, 7));
    end
    cyc(); rst = 1'b0; bus.req = 2'b00;
    repeat (6) cyc();
    smp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
